// File: rtl/fifo_ptr_pkg.sv
// Shared pointer defaults and Gray/binary helpers for both sides of the async FIFO.
// Conversions operate on 32-bit values; callers cast to their pointer width.
package fifo_ptr_pkg;

    localparam int ADDR_W_DEF   = 3;
    localparam int PW_DEF       = ADDR_W_DEF + 1;
    localparam int AFULL_TH_DEF = 6;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b     = '0;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded bus; output lags input by 2 edges.
// Synchronous active-high reset clears both stages.
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q1;
    logic [W-1:0] r_q2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q1 <= '0;
            r_q2 <= '0;
        end else begin
            r_q1 <= i_d;
            r_q2 <= r_q1;
        end
    end

    assign o_q = r_q2;

endmodule

// File: rtl/wr_full_ctrl.sv
// Write-side pointer/flag controller of an async FIFO: Gray pointer export, full, almost_full, level.
// wr_en is combinational; flags update 1 edge after a push, 3 edges after a read-pointer change.
// Optional sticky overflow flag enabled by macro WR_OVERFLOW_DET_EN (tied to 0 otherwise).
module wr_full_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter  int ADDR_W   = ADDR_W_DEF,
    parameter  int AFULL_TH = AFULL_TH_DEF,
    localparam int PW       = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [PW-1:0]     rgray_async,
    output logic              wr_en,
    output logic [ADDR_W-1:0] waddr,
    output logic [PW-1:0]     wgray,
    output logic              full,
    output logic              almost_full,
    output logic [PW-1:0]     wlevel,
    output logic              overflow
);

    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wgray;
    logic          r_full;
    logic          r_afull;
    logic [PW-1:0] r_wlevel;

    logic          w_wr_en;
    logic [PW-1:0] w_wbin_next;
    logic [PW-1:0] w_wgray_next;
    logic [PW-1:0] w_rq2;
    logic [PW-1:0] w_rbin_s;
    logic [PW-1:0] w_full_cmp;
    logic [PW-1:0] w_level_next;

    sync_2ff #(.W(PW)) u_rptr_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rgray_async),
        .o_q   (w_rq2)
    );

    assign w_wr_en      = push & ~r_full & ~reset;
    assign w_wbin_next  = r_wbin + {{(PW-1){1'b0}}, w_wr_en};
    assign w_wgray_next = PW'(bin2gray(32'(w_wbin_next)));
    assign w_rbin_s     = PW'(gray2bin(32'(w_rq2)));
    // Full when the write pointer is exactly one lap (depth) ahead of the synced read pointer.
    assign w_full_cmp   = {~w_rq2[PW-1:PW-2], w_rq2[PW-3:0]};
    assign w_level_next = w_wbin_next - w_rbin_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wbin   <= '0;
            r_wgray  <= '0;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_wlevel <= '0;
        end else begin
            r_wbin   <= w_wbin_next;
            r_wgray  <= w_wgray_next;
            r_full   <= (w_wgray_next == w_full_cmp);
            r_afull  <= (int'(w_level_next) >= AFULL_TH);
            r_wlevel <= w_level_next;
        end
    end

`ifdef WR_OVERFLOW_DET_EN
    logic r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (push && r_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`else
    assign overflow = 1'b0;
`endif

    assign wr_en       = w_wr_en;
    assign waddr       = r_wbin[ADDR_W-1:0];
    assign wgray       = r_wgray;
    assign full        = r_full;
    assign almost_full = r_afull;
    assign wlevel      = r_wlevel;

endmodule

// File: tb/tb_wr_full_ctrl.sv
// Bench for wr_full_ctrl: directed vector table, corner-case sequences and a random run against an occupancy model.
module tb_wr_full_ctrl;

`ifdef WR_OVERFLOW_DET_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic [3:0] rgray_async;
    logic       wr_en;
    logic [2:0] waddr;
    logic [3:0] wgray;
    logic       full;
    logic       almost_full;
    logic [3:0] wlevel;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    wr_full_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .rgray_async (rgray_async),
        .wr_en       (wr_en),
        .waddr       (waddr),
        .wgray       (wgray),
        .full        (full),
        .almost_full (almost_full),
        .wlevel      (wlevel),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int to_gray(input int i);
        return (i ^ (i >> 1)) & 15;
    endfunction

    // Decode by searching the Gray sequence rather than by bitwise XOR chain.
    function automatic int from_gray(input int g);
        for (int i = 0; i < 16; i++) begin
            if (to_gray(i) == g) return i;
        end
        return -1;
    endfunction

    typedef struct {
        bit reset;
        bit push;
        int rgray;
        bit exp_wren;
        int exp_wgray;
        bit exp_full;
        bit exp_afull;
        int exp_wlevel;
        bit exp_ovf;
    } vec_t;

    vec_t vecs[14];

    task automatic step_vec(input int idx, input vec_t v);
        @(negedge clk);
        reset = v.reset; push = v.push; rgray_async = 4'(v.rgray);
        #1;
        chk($sformatf("v%0d_wr_en", idx), int'(wr_en), int'(v.exp_wren));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_wgray", idx), int'(wgray), v.exp_wgray);
        chk($sformatf("v%0d_full", idx), int'(full), int'(v.exp_full));
        chk($sformatf("v%0d_afull", idx), int'(almost_full), int'(v.exp_afull));
        chk($sformatf("v%0d_wlevel", idx), int'(wlevel), v.exp_wlevel);
        chk($sformatf("v%0d_overflow", idx), int'(overflow), int'(v.exp_ovf));
    endtask

    task automatic cycle(input bit r, input bit p, input int rg);
        @(negedge clk);
        reset = r; push = p; rgray_async = 4'(rg);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wraps, saw8to0, full_seen, prev_waddr, prev_wgray;
        int m_wcnt, m_rc, m_s1, m_s2, m_lv;
        bit m_full, m_af, m_ovf, r, p;

        reset = 1'b1; push = 1'b0; rgray_async = '0;

        // Reset, fill to full, overflow push, then read-pointer release.
        vecs[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int k = 1; k <= 8; k++)
            vecs[k+1] = '{0, 1, 0, 1, to_gray(k), k == 8, k >= 6, k, 0};
        vecs[10] = '{0, 1, 0, 0, 'hC, 1, 1, 8, OVF_EN};
        vecs[11] = '{0, 0, 1, 0, 'hC, 1, 1, 8, OVF_EN};
        vecs[12] = '{0, 0, 1, 0, 'hC, 1, 1, 8, OVF_EN};
        vecs[13] = '{0, 0, 1, 0, 'hC, 0, 1, 7, OVF_EN};

        for (int i = 0; i < 14; i++) step_vec(i, vecs[i]);
        chk("fill_waddr", int'(waddr), 0);

        for (int i = 0; i < 10; i++) cycle(0, 0, 1);
        chk("ovf_sticky", int'(overflow), int'(OVF_EN));

        // Wrap: reader tracks the exported write pointer, so full must never assert.
        cycle(1, 0, 0);
        wraps = 0; saw8to0 = 0; full_seen = 0;
        prev_waddr = int'(waddr); prev_wgray = int'(wgray);
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, int'(wgray));
            if (full) full_seen++;
            if (prev_waddr == 7 && waddr == 0) wraps++;
            if (prev_wgray == 8 && wgray == 0) saw8to0++;
            prev_waddr = int'(waddr); prev_wgray = int'(wgray);
        end
        chk("wrap_full_seen", full_seen, 0);
        chk("wrap_waddr_wraps", wraps, 2);
        chk("wrap_gray_8_to_0", saw8to0, 1);
        chk("wrap_waddr_end", int'(waddr), 4);

        // Reset mid-fill.
        cycle(1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0);
        chk("midrst_level5", int'(wlevel), 5);
        @(negedge clk);
        reset = 1'b1; push = 1'b1;
        #1;
        chk("midrst_wren_in_reset", int'(wr_en), 0);
        @(posedge clk);
        #1;
        chk("midrst_wgray", int'(wgray), 0);
        chk("midrst_wlevel", int'(wlevel), 0);
        chk("midrst_waddr", int'(waddr), 0);
        chk("midrst_flags", int'({full, almost_full, overflow}), 0);
        cycle(0, 1, 0);
        chk("midrst_first_push", int'(wgray), 1);

        // Random run against an occupancy model.
        cycle(1, 0, 0);
        m_wcnt = 0; m_rc = 0; m_s1 = 0; m_s2 = 0; m_lv = 0;
        m_full = 0; m_af = 0; m_ovf = 0;
        for (int c = 0; c < 600; c++) begin
            r = ($urandom_range(0, 79) == 0);
            p = ($urandom_range(0, 3) != 0);
            if (r) m_rc = 0;
            else if (m_rc != m_wcnt && $urandom_range(0, 2) == 0) m_rc = (m_rc + 1) % 16;
            @(negedge clk);
            reset = r; push = p; rgray_async = 4'(to_gray(m_rc));
            #1;
            chk("rnd_wr_en", int'(wr_en), int'(p && !m_full && !r));
            @(posedge clk);
            if (r) begin
                m_wcnt = 0; m_s1 = 0; m_s2 = 0; m_lv = 0;
                m_full = 0; m_af = 0; m_ovf = 0;
            end else begin
                if (p && m_full) m_ovf = 1;
                if (p && !m_full) m_wcnt = (m_wcnt + 1) % 16;
                m_lv   = (m_wcnt - from_gray(m_s2) + 16) % 16;
                m_full = (m_lv == 8);
                m_af   = (m_lv >= 6);
                m_s2   = m_s1;
                m_s1   = to_gray(m_rc);
            end
            #1;
            chk("rnd_wgray", int'(wgray), to_gray(m_wcnt));
            chk("rnd_waddr", int'(waddr), m_wcnt % 8);
            chk("rnd_wlevel", int'(wlevel), m_lv);
            chk("rnd_full", int'(full), int'(m_full));
            chk("rnd_afull", int'(almost_full), int'(m_af));
            chk("rnd_overflow", int'(overflow), int'(OVF_EN && m_ovf));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
